// File: rtl/serial_bit_source.sv
// Parallel-to-serial bit source: accepts WIDTH-bit words over valid/ready and emits one bit per clk.
// A one-word holding register lets consecutive words stream with no idle gap between them.
module serial_bit_source #(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             a_out,
   output logic             bit_valid,
   output logic             last,
   output logic             busy,
   output logic [7:0]       word_count
);

   localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] hreg_q, hreg_d;
   logic             hvalid_q, hvalid_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [7:0]       word_count_q, word_count_d;
   logic             accept;

   // The output end of sreg is the MSB or the LSB depending on bit order.
   function automatic logic head_bit(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   function automatic logic [WIDTH-1:0] shift_toward_head(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
   endfunction

   assign accept = din_valid && !hvalid_q;

   always_comb begin
      state_d      = state_q;
      sreg_d       = sreg_q;
      hreg_d       = hreg_q;
      hvalid_d     = hvalid_q;
      cnt_d        = cnt_q;
      word_count_d = word_count_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sreg_d  = din;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != LAST_CNT) begin
               sreg_d = shift_toward_head(sreg_q);
               cnt_d  = cnt_q + CW'(1);
               if (accept) begin
                  hreg_d   = din;
                  hvalid_d = 1'b1;
               end
            end else begin
               // Final bit of the word: reload from the holding register, then a
               // direct handshake, so back-to-back words keep bit_valid contiguous.
               word_count_d = word_count_q + 8'd1;
               cnt_d        = '0;
               if (hvalid_q) begin
                  sreg_d   = hreg_q;
                  hvalid_d = 1'b0;
               end else if (accept) begin
                  sreg_d = din;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         sreg_q       <= '0;
         hreg_q       <= '0;
         hvalid_q     <= 1'b0;
         cnt_q        <= '0;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         sreg_q       <= sreg_d;
         hreg_q       <= hreg_d;
         hvalid_q     <= hvalid_d;
         cnt_q        <= cnt_d;
         word_count_q <= word_count_d;
      end
   end

   // All outputs decode from registers only.
   assign din_ready  = !hvalid_q;
   assign bit_valid  = (state_q == SHIFT);
   assign last       = (state_q == SHIFT) && (cnt_q == LAST_CNT);
   assign busy       = (state_q == SHIFT) || hvalid_q;
   assign a_out      = (state_q == SHIFT) ? head_bit(sreg_q) : IDLE_BIT;
   assign word_count = word_count_q;

endmodule
